// File: rtl/ifid_stall_ctrl.sv
`default_nettype none
// ifid_stall_ctrl: fetch/decode hazard and stall sequencer on the cache clock.
// Registered PC/IF-ID/ID-EX controls, saturating stall counter, sticky miss timeout.
module ifid_stall_ctrl #(
  parameter int CNT_W        = 16,
  parameter int MISS_TIMEOUT = 64,
  parameter int TO_W         = 7
) (
  input  logic             CCLK,
  input  logic             RESET,
  input  logic             IC_MISS,
  input  logic             IC_READY,
  input  logic             DC_MISS,
  input  logic             DC_READY,
  input  logic             IDEX_MEMREAD,
  input  logic [4:0]       IDEX_RT,
  input  logic [4:0]       IFID_RS,
  input  logic [4:0]       IFID_RT,
  input  logic             BR_TAKEN,
  output logic             PC_WRITE,
  output logic             IFID_WRITE,
  output logic             IF_FLUSH,
  output logic             IDEX_BUBBLE,
  output logic [1:0]       STATE,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic             ERR
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    IMISS = 2'd1,
    DMISS = 2'd2,
    REDIR = 2'd3
  } state_t;

  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(MISS_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t          state_q;
  state_t          state_d;
  logic            pc_write_d;
  logic            ifid_write_d;
  logic            if_flush_d;
  logic            bubble_d;
  logic            run_eval;
  logic            luh;
  logic            miss_d;
  logic            enter_miss;
  logic [TO_W-1:0] to_cnt_q;
  logic [TO_W-1:0] to_cnt_d;
  logic            err_d;
  logic [CNT_W-1:0] stall_cnt_d;

  assign luh = IDEX_MEMREAD & (IDEX_RT != 5'd0) &
               ((IDEX_RT == IFID_RS) | (IDEX_RT == IFID_RT));

  // run_eval marks every cycle where the RUN priority rules decide the next state
  always_comb begin
    state_d      = state_q;
    pc_write_d   = 1'b0;
    ifid_write_d = 1'b0;
    if_flush_d   = 1'b0;
    bubble_d     = 1'b0;
    run_eval     = 1'b0;
    case (state_q)
      RUN, REDIR: run_eval = 1'b1;
      IMISS: begin
        if (DC_MISS || IC_READY) begin
          run_eval = 1'b1;
        end else begin
          bubble_d = 1'b1;
        end
      end
      DMISS: begin
        if (DC_READY) begin
          run_eval = 1'b1;
        end
      end
      default: run_eval = 1'b1;
    endcase
    if (run_eval) begin
      if (DC_MISS) begin
        state_d = DMISS;
      end else if (BR_TAKEN) begin
        state_d    = REDIR;
        if_flush_d = 1'b1;
        pc_write_d = 1'b1;
      end else if (IC_MISS) begin
        state_d  = IMISS;
        bubble_d = 1'b1;
      end else if (luh) begin
        state_d  = RUN;
        bubble_d = 1'b1;
      end else begin
        state_d      = RUN;
        pc_write_d   = 1'b1;
        ifid_write_d = 1'b1;
      end
    end
  end

  // Every entry into a miss state (including re-entry on READY) passes through run_eval.
  // The timeout counter holds the ordinal of the current miss cycle, zero outside a miss.
  assign miss_d     = (state_d == IMISS) || (state_d == DMISS);
  assign enter_miss = miss_d && run_eval;

  always_comb begin
    if (!miss_d) begin
      to_cnt_d = '0;
    end else if (enter_miss) begin
      to_cnt_d = TO_W'(1);
    end else if (to_cnt_q == TO_LIMIT) begin
      to_cnt_d = to_cnt_q;
    end else begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  assign err_d = ERR | (miss_d && (to_cnt_d == TO_LIMIT));

  assign stall_cnt_d = (!pc_write_d && (STALL_CNT != CNT_MAX)) ?
                       STALL_CNT + CNT_W'(1) : STALL_CNT;

  always_ff @(posedge CCLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= RUN;
      PC_WRITE    <= 1'b0;
      IFID_WRITE  <= 1'b0;
      IF_FLUSH    <= 1'b0;
      IDEX_BUBBLE <= 1'b0;
      STALL_CNT   <= '0;
      ERR         <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      PC_WRITE    <= pc_write_d;
      IFID_WRITE  <= ifid_write_d;
      IF_FLUSH    <= if_flush_d;
      IDEX_BUBBLE <= bubble_d;
      STALL_CNT   <= stall_cnt_d;
      ERR         <= err_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  assign STATE = state_q;

endmodule
`default_nettype wire

// File: tb/tb_ifid_stall_ctrl.sv
`default_nettype none
// tb_ifid_stall_ctrl: directed scenario tasks with hand-computed expectations.
module tb_ifid_stall_ctrl;

  logic        cclk = 1'b0;
  logic        reset = 1'b0;
  logic        ic_miss, ic_ready, dc_miss, dc_ready, idex_memread, br_taken;
  logic [4:0]  idex_rt, ifid_rs, ifid_rt;
  logic        pc_write, ifid_write, if_flush, idex_bubble, err;
  logic [1:0]  state;
  logic [15:0] stall_cnt;
  logic        pc_write4, ifid_write4, if_flush4, idex_bubble4, err4;
  logic [1:0]  state4;
  logic [3:0]  stall_cnt4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 cclk = ~cclk;

  ifid_stall_ctrl #(.CNT_W(16), .MISS_TIMEOUT(64), .TO_W(7)) dut (
    .CCLK(cclk), .RESET(reset), .IC_MISS(ic_miss), .IC_READY(ic_ready),
    .DC_MISS(dc_miss), .DC_READY(dc_ready), .IDEX_MEMREAD(idex_memread),
    .IDEX_RT(idex_rt), .IFID_RS(ifid_rs), .IFID_RT(ifid_rt), .BR_TAKEN(br_taken),
    .PC_WRITE(pc_write), .IFID_WRITE(ifid_write), .IF_FLUSH(if_flush),
    .IDEX_BUBBLE(idex_bubble), .STATE(state), .STALL_CNT(stall_cnt), .ERR(err)
  );

  ifid_stall_ctrl #(.CNT_W(4), .MISS_TIMEOUT(64), .TO_W(7)) dut4 (
    .CCLK(cclk), .RESET(reset), .IC_MISS(ic_miss), .IC_READY(ic_ready),
    .DC_MISS(dc_miss), .DC_READY(dc_ready), .IDEX_MEMREAD(idex_memread),
    .IDEX_RT(idex_rt), .IFID_RS(ifid_rs), .IFID_RT(ifid_rt), .BR_TAKEN(br_taken),
    .PC_WRITE(pc_write4), .IFID_WRITE(ifid_write4), .IF_FLUSH(if_flush4),
    .IDEX_BUBBLE(idex_bubble4), .STATE(state4), .STALL_CNT(stall_cnt4), .ERR(err4)
  );

  task automatic idle();
    ic_miss = 0; ic_ready = 0; dc_miss = 0; dc_ready = 0;
    idex_memread = 0; br_taken = 0; idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
  endtask

  task automatic step();
    @(posedge cclk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    @(negedge cclk);
    reset = 1'b1;
    #1;
    @(negedge cclk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({state, pc_write, ifid_write, if_flush, idex_bubble, err} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got st=%0d pc=%b ifid=%b fl=%b bub=%b err=%b want all 0",
               state, pc_write, ifid_write, if_flush, idex_bubble, err);
    end
    n_tests++;
    if (stall_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt);
    end
    step();
    n_tests++;
    if ({state, pc_write, ifid_write, if_flush, idex_bubble, err} !== 7'b00_1100_0) begin
      n_fail++;
      $display("FAIL idle_ctrl: got st=%0d pc=%b ifid=%b fl=%b bub=%b err=%b want st=0 pc=1 ifid=1 rest 0",
               state, pc_write, ifid_write, if_flush, idex_bubble, err);
    end
    n_tests++;
    if (stall_cnt !== 16'd0) begin
      n_fail++; $display("FAIL idle_cnt: got %0d want 0", stall_cnt);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    step();
    idex_memread = 1; idex_rt = 5; ifid_rs = 5;
    step();
    n_tests++;
    if ({pc_write, ifid_write, idex_bubble, state} !== 5'b001_00 || stall_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL luh_stall: got pc=%b ifid=%b bub=%b st=%0d cnt=%0d want pc=0 ifid=0 bub=1 st=0 cnt=1",
               pc_write, ifid_write, idex_bubble, state, stall_cnt);
    end
    idle();
    step();
    n_tests++;
    if ({pc_write, ifid_write, idex_bubble} !== 3'b110 || stall_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL luh_release: got pc=%b ifid=%b bub=%b cnt=%0d want pc=1 ifid=1 bub=0 cnt=1",
               pc_write, ifid_write, idex_bubble, stall_cnt);
    end
    // rt-field match held two cycles stalls twice
    idex_memread = 1; idex_rt = 7; ifid_rt = 7; ifid_rs = 3;
    step();
    step();
    n_tests++;
    if ({pc_write, idex_bubble} !== 2'b01 || stall_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL luh_persist: got pc=%b bub=%b cnt=%0d want pc=0 bub=1 cnt=3",
               pc_write, idex_bubble, stall_cnt);
    end
    idle();
    idex_memread = 1; idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
    step();
    n_tests++;
    if ({pc_write, idex_bubble} !== 2'b10 || stall_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL luh_r0: got pc=%b bub=%b cnt=%0d want pc=1 bub=0 cnt=3",
               pc_write, idex_bubble, stall_cnt);
    end
    idle();
  endtask

  task automatic test_branch();
    do_reset();
    step();
    br_taken = 1; ic_miss = 1;
    step();
    n_tests++;
    if ({state, if_flush, pc_write, ifid_write, idex_bubble} !== 6'b11_1100) begin
      n_fail++;
      $display("FAIL br_redir: got st=%0d fl=%b pc=%b ifid=%b bub=%b want st=3 fl=1 pc=1 ifid=0 bub=0",
               state, if_flush, pc_write, ifid_write, idex_bubble);
    end
    br_taken = 0;
    step();
    n_tests++;
    if ({state, if_flush, pc_write, idex_bubble} !== 5'b01_001) begin
      n_fail++;
      $display("FAIL br_then_imiss: got st=%0d fl=%b pc=%b bub=%b want st=1 fl=0 pc=0 bub=1",
               state, if_flush, pc_write, idex_bubble);
    end
    ic_miss = 0; br_taken = 1;
    step();
    n_tests++;
    if ({state, if_flush} !== 3'b01_0) begin
      n_fail++; $display("FAIL imiss_ignores_br: got st=%0d fl=%b want st=1 fl=0", state, if_flush);
    end
    br_taken = 0; ic_ready = 1;
    step();
    n_tests++;
    if ({state, pc_write, ifid_write} !== 4'b00_11 || stall_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL imiss_ready: got st=%0d pc=%b ifid=%b cnt=%0d want st=0 pc=1 ifid=1 cnt=2",
               state, pc_write, ifid_write, stall_cnt);
    end
    idle();
  endtask

  task automatic test_imiss_dmiss();
    do_reset();
    step();
    ic_miss = 1;
    step();
    ic_miss = 0;
    repeat (3) step();
    n_tests++;
    if ({state, idex_bubble} !== 3'b01_1) begin
      n_fail++; $display("FAIL imiss_hold: got st=%0d bub=%b want st=1 bub=1", state, idex_bubble);
    end
    dc_miss = 1;
    step();
    n_tests++;
    if ({state, pc_write, ifid_write, idex_bubble} !== 5'b10_000) begin
      n_fail++;
      $display("FAIL imiss_to_dmiss: got st=%0d pc=%b ifid=%b bub=%b want st=2 pc=0 ifid=0 bub=0",
               state, pc_write, ifid_write, idex_bubble);
    end
    dc_miss = 0; ic_miss = 1; ic_ready = 1; br_taken = 1;
    repeat (9) step();
    n_tests++;
    if ({state, if_flush} !== 3'b10_0) begin
      n_fail++; $display("FAIL dmiss_ignores: got st=%0d fl=%b want st=2 fl=0", state, if_flush);
    end
    idle();
    dc_ready = 1;
    step();
    n_tests++;
    if ({state, pc_write} !== 3'b00_1 || stall_cnt !== 16'd14 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL dmiss_release: got st=%0d pc=%b cnt=%0d err=%b want st=0 pc=1 cnt=14 err=0",
               state, pc_write, stall_cnt, err);
    end
    idle();
  endtask

  task automatic test_priority_reentry();
    do_reset();
    step();
    dc_miss = 1; br_taken = 1; ic_miss = 1;
    step();
    n_tests++;
    if ({state, if_flush, pc_write} !== 4'b10_00) begin
      n_fail++;
      $display("FAIL dc_over_br: got st=%0d fl=%b pc=%b want st=2 fl=0 pc=0", state, if_flush, pc_write);
    end
    idle();
    dc_ready = 1; dc_miss = 1;
    step();
    n_tests++;
    if (state !== 2'd2) begin
      n_fail++; $display("FAIL dmiss_reenter: got st=%0d want 2", state);
    end
    idle();
    dc_ready = 1;
    step();
    n_tests++;
    if ({state, pc_write} !== 3'b00_1 || stall_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL reenter_release: got st=%0d pc=%b cnt=%0d want st=0 pc=1 cnt=2",
               state, pc_write, stall_cnt);
    end
    idle();
  endtask

  task automatic test_timeout();
    do_reset();
    step();
    dc_miss = 1;
    step();
    dc_miss = 0;
    repeat (62) step();
    n_tests++;
    if ({state, err} !== 3'b10_0) begin
      n_fail++; $display("FAIL to_early: got st=%0d err=%b want st=2 err=0 on cycle 63", state, err);
    end
    step();
    n_tests++;
    if ({state, err} !== 3'b10_1) begin
      n_fail++; $display("FAIL to_set: got st=%0d err=%b want st=2 err=1 on cycle 64", state, err);
    end
    dc_ready = 1;
    step();
    n_tests++;
    if ({state, err, pc_write} !== 4'b00_1_1) begin
      n_fail++;
      $display("FAIL to_sticky: got st=%0d err=%b pc=%b want st=0 err=1 pc=1", state, err, pc_write);
    end
    idle();
    @(negedge cclk);
    reset = 1'b1;
    #1;
    n_tests++;
    if (err !== 1'b0 || stall_cnt !== 16'd0) begin
      n_fail++; $display("FAIL to_reset: got err=%b cnt=%0d want err=0 cnt=0", err, stall_cnt);
    end
    @(negedge cclk);
    reset = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    step();
    dc_miss = 1;
    step();
    dc_miss = 0;
    repeat (14) step();
    n_tests++;
    if (stall_cnt4 !== 4'd15) begin
      n_fail++; $display("FAIL sat_reach: got %0d want 15 after 15 stalls", stall_cnt4);
    end
    repeat (5) step();
    n_tests++;
    if (stall_cnt4 !== 4'd15 || stall_cnt !== 16'd20) begin
      n_fail++;
      $display("FAIL sat_hold: got cnt4=%0d cnt16=%0d want cnt4=15 cnt16=20", stall_cnt4, stall_cnt);
    end
    dc_ready = 1;
    step();
    n_tests++;
    if ({state4, pc_write4} !== 3'b00_1 || stall_cnt4 !== 4'd15) begin
      n_fail++;
      $display("FAIL sat_release: got st=%0d pc=%b cnt4=%0d want st=0 pc=1 cnt4=15",
               state4, pc_write4, stall_cnt4);
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_branch();
    test_imiss_dmiss();
    test_priority_reentry();
    test_timeout();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
